// File: rtl/axi_store_bus_pkg.sv
// ============================================================================
// Module   : axi_store_bus_pkg
// Purpose  : Shared types and widths for the three-master AXI3 write bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_store_bus_pkg;

    localparam int NUM_M  = 3;
    localparam int SEL_W  = 2;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [1:0]        lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
    } aw_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_t;

endpackage

`default_nettype wire

// File: rtl/store_bus_arbiter.sv
// ============================================================================
// Module   : store_bus_arbiter
// Purpose  : Round-robin grant register, held until the owner releases it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_bus_arbiter
    import axi_store_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_M-1:0] i_req,
    input  logic             i_release,
    output logic [NUM_M-1:0] o_grnt
);

    logic [NUM_M-1:0] r_grnt;
    logic [SEL_W-1:0] r_last;
    logic [NUM_M-1:0] w_win;
    logic [SEL_W-1:0] w_win_idx;
    logic             w_found;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = r_last;
        for (int k = 1; k <= NUM_M; k++) begin
            if (!w_found && i_req[(int'(r_last) + k) % NUM_M]) begin
                w_found   = 1'b1;
                w_win_idx = SEL_W'((int'(r_last) + k) % NUM_M);
            end
        end
        w_win = w_found ? ({{(NUM_M-1){1'b0}}, 1'b1} << w_win_idx) : '0;
    end

    // Pointer resets to the last master so m0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grnt <= '0;
            r_last <= SEL_W'(NUM_M - 1);
        end else if (i_release) begin
            r_grnt <= '0;
        end else if ((r_grnt == '0) && w_found) begin
            r_grnt <= w_win;
            r_last <= w_win_idx;
        end
    end

    assign o_grnt = r_grnt;

endmodule

`default_nettype wire

// File: rtl/axi_cache_store_bus.sv
// ============================================================================
// Module   : axi_cache_store_bus
// Purpose  : Three-master AXI3 write bus; one transaction owns AW/W/B at a time.
//            Define AXI_STORE_BUS_LEN_CHECK_EN to generate wlast from awlen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_cache_store_bus
    import axi_store_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [ID_W-1:0]   wid,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    input  logic              m0_req,
    output logic              m0_grnt,
    input  logic [ID_W-1:0]   m0_awid,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic [LEN_W-1:0]  m0_awlen,
    input  logic [2:0]        m0_awsize,
    input  logic [1:0]        m0_awburst,
    input  logic [1:0]        m0_awlock,
    input  logic [3:0]        m0_awcache,
    input  logic [2:0]        m0_awprot,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [ID_W-1:0]   m0_wid,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic              m0_wlast,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    output logic [ID_W-1:0]   m0_bid,
    output logic [1:0]        m0_bresp,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    input  logic              m1_req,
    output logic              m1_grnt,
    input  logic [ID_W-1:0]   m1_awid,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic [LEN_W-1:0]  m1_awlen,
    input  logic [2:0]        m1_awsize,
    input  logic [1:0]        m1_awburst,
    input  logic [1:0]        m1_awlock,
    input  logic [3:0]        m1_awcache,
    input  logic [2:0]        m1_awprot,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [ID_W-1:0]   m1_wid,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wlast,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic [ID_W-1:0]   m1_bid,
    output logic [1:0]        m1_bresp,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    input  logic              m2_req,
    output logic              m2_grnt,
    input  logic [ID_W-1:0]   m2_awid,
    input  logic [ADDR_W-1:0] m2_awaddr,
    input  logic [LEN_W-1:0]  m2_awlen,
    input  logic [2:0]        m2_awsize,
    input  logic [1:0]        m2_awburst,
    input  logic [1:0]        m2_awlock,
    input  logic [3:0]        m2_awcache,
    input  logic [2:0]        m2_awprot,
    input  logic              m2_awvalid,
    output logic              m2_awready,
    input  logic [ID_W-1:0]   m2_wid,
    input  logic [DATA_W-1:0] m2_wdata,
    input  logic [STRB_W-1:0] m2_wstrb,
    input  logic              m2_wlast,
    input  logic              m2_wvalid,
    output logic              m2_wready,
    output logic [ID_W-1:0]   m2_bid,
    output logic [1:0]        m2_bresp,
    output logic              m2_bvalid,
    input  logic              m2_bready,
    output logic              len_err
);

    aw_t              w_m_aw [NUM_M];
    w_t               w_m_w  [NUM_M];
    logic [NUM_M-1:0] w_req, w_awvalid, w_wvalid, w_bready, w_grnt;
    logic [NUM_M-1:0] w_m_awready, w_m_wready, w_m_bvalid;
    aw_t              w_sel_aw;
    w_t               w_sel_w;
    logic             w_sel_awvalid, w_sel_wvalid, w_sel_bready;
    logic             w_wfire, w_wlast_out, w_release;
    state_e           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_beat, r_awlen;

    assign w_m_aw[0] = {m0_awid, m0_awaddr, m0_awlen, m0_awsize, m0_awburst, m0_awlock, m0_awcache, m0_awprot};
    assign w_m_aw[1] = {m1_awid, m1_awaddr, m1_awlen, m1_awsize, m1_awburst, m1_awlock, m1_awcache, m1_awprot};
    assign w_m_aw[2] = {m2_awid, m2_awaddr, m2_awlen, m2_awsize, m2_awburst, m2_awlock, m2_awcache, m2_awprot};
    assign w_m_w[0]  = {m0_wid, m0_wdata, m0_wstrb, m0_wlast};
    assign w_m_w[1]  = {m1_wid, m1_wdata, m1_wstrb, m1_wlast};
    assign w_m_w[2]  = {m2_wid, m2_wdata, m2_wstrb, m2_wlast};
    assign w_req     = {m2_req, m1_req, m0_req};
    assign w_awvalid = {m2_awvalid, m1_awvalid, m0_awvalid};
    assign w_wvalid  = {m2_wvalid, m1_wvalid, m0_wvalid};
    assign w_bready  = {m2_bready, m1_bready, m0_bready};

    store_bus_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req),
        .i_release (w_release),
        .o_grnt    (w_grnt)
    );

    // One-hot grant: zero grant leaves every selected field at zero.
    always_comb begin
        w_sel_aw      = '0;
        w_sel_w       = '0;
        w_sel_awvalid = 1'b0;
        w_sel_wvalid  = 1'b0;
        w_sel_bready  = 1'b0;
        for (int n = 0; n < NUM_M; n++) begin
            if (w_grnt[n]) begin
                w_sel_aw      = w_m_aw[n];
                w_sel_w       = w_m_w[n];
                w_sel_awvalid = w_awvalid[n];
                w_sel_wvalid  = w_wvalid[n];
                w_sel_bready  = w_bready[n];
            end
        end
    end

    assign w_wfire   = (r_state == ST_W) && w_sel_wvalid && wready;
    assign w_release = (r_state == ST_B) && bvalid && bready;

`ifdef AXI_STORE_BUS_LEN_CHECK_EN
    logic r_len_err;

    assign w_wlast_out = (r_state == ST_W) && (r_beat == r_awlen);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_err <= 1'b0;
        end else if (w_wfire && (w_sel_w.last != w_wlast_out)) begin
            r_len_err <= 1'b1;
        end
    end

    assign len_err = r_len_err;
`else
    assign w_wlast_out = w_sel_w.last;
    assign len_err     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_req)                     w_state_nxt = ST_AW;
            ST_AW:   if (awvalid && awready)         w_state_nxt = ST_W;
            ST_W:    if (w_wfire && w_wlast_out)     w_state_nxt = ST_B;
            ST_B:    if (w_release)                  w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter holds at awlen so an overlong master burst cannot wrap it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_awlen <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_AW) && awvalid && awready) begin
                r_awlen <= w_sel_aw.len;
                r_beat  <= '0;
            end else if (w_wfire && (r_beat != r_awlen)) begin
                r_beat  <= r_beat + 1'b1;
            end
        end
    end

    assign awid    = w_sel_aw.id;
    assign awaddr  = w_sel_aw.addr;
    assign awlen   = w_sel_aw.len;
    assign awsize  = w_sel_aw.size;
    assign awburst = w_sel_aw.burst;
    assign awlock  = w_sel_aw.lock;
    assign awcache = w_sel_aw.cache;
    assign awprot  = w_sel_aw.prot;
    assign awvalid = (r_state == ST_AW) && w_sel_awvalid;
    assign wid     = w_sel_w.id;
    assign wdata   = w_sel_w.data;
    assign wstrb   = w_sel_w.strb;
    assign wlast   = w_wlast_out;
    assign wvalid  = (r_state == ST_W) && w_sel_wvalid;
    assign bready  = (r_state == ST_B) && w_sel_bready;

    assign w_m_awready = w_grnt & {NUM_M{(r_state == ST_AW) && awready}};
    assign w_m_wready  = w_grnt & {NUM_M{(r_state == ST_W) && wready}};
    assign w_m_bvalid  = w_grnt & {NUM_M{(r_state == ST_B) && bvalid}};

    assign {m2_grnt, m1_grnt, m0_grnt}          = w_grnt;
    assign {m2_awready, m1_awready, m0_awready} = w_m_awready;
    assign {m2_wready, m1_wready, m0_wready}    = w_m_wready;
    assign {m2_bvalid, m1_bvalid, m0_bvalid}    = w_m_bvalid;
    assign m0_bid   = w_grnt[0] ? bid   : '0;
    assign m0_bresp = w_grnt[0] ? bresp : '0;
    assign m1_bid   = w_grnt[1] ? bid   : '0;
    assign m1_bresp = w_grnt[1] ? bresp : '0;
    assign m2_bid   = w_grnt[2] ? bid   : '0;
    assign m2_bresp = w_grnt[2] ? bresp : '0;

endmodule

`default_nettype wire
